// File: rtl/s2p_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package s2p_deser_pkg;

  // Assembly FSM: IDLE holds no bits, SHIFT holds 1..DWIDTH-1 bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/s2p_outreg.sv
// Output holding register with valid/ready handshake for assembled words.
// Latency: a loaded word is visible on outdata_o/outvalid_o one clock after word_vld_i.
// Backpressure: held word is kept while outready_i=0; a word completing then is dropped with an overflow_o pulse.
//
// Ports:
//   clk, rstn     clock, async active-low reset
//   word_vld_i    a completed word is offered this cycle
//   word_dat_i    the completed word
//   outready_i    downstream accepts the held word (ignored while outvalid_o=0)
//   outdata_o     held word
//   outvalid_o    outdata_o holds an unconsumed word
//   overflow_o    one-cycle pulse when an offered word is dropped
module s2p_outreg #(
  parameter int DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              word_vld_i,
  input  logic [DWIDTH-1:0] word_dat_i,
  input  logic              outready_i,
  output logic [DWIDTH-1:0] outdata_o,
  output logic              outvalid_o,
  output logic              overflow_o
);

  logic [DWIDTH-1:0] dat_q;
  logic              vld_q;
  logic              ovf_q;

  // The register has room for a new word when it is empty or its word is
  // leaving this cycle; outready_i only matters while a word is held.
  logic xfer;
  logic room;

  assign xfer = vld_q & outready_i;
  assign room = ~vld_q | outready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dat_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (word_vld_i) begin
        if (room) begin
          // Completion alongside a transfer reloads without a bubble.
          dat_q <= word_dat_i;
          vld_q <= 1'b1;
        end else begin
          // Held word wins; the newcomer is dropped and flagged.
          ovf_q <= 1'b1;
        end
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign outdata_o  = dat_q;
  assign outvalid_o = vld_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/s2p_deser.sv
// Serial-to-parallel deserializer: gathers DWIDTH qualified bits into a word.
// Latency: word visible on outdata/outvalid one clock after its last bit; back-to-back words lose no cycle.
// Backpressure: none on the serial side; a word completing while the held word is unconsumed is dropped (overflow).
//
// Ports:
//   clk, rstn   clock, async active-low reset
//   din         serial data bit
//   invalid     din qualifier, one bit accepted per cycle while high
//   outdata     assembled word        outvalid  outdata holds an unconsumed word
//   outready    downstream accepts    busy      a partial word is in progress
//   overflow    pulse: completed word dropped
//   abort       pulse: partial word discarded after TIMEOUT idle cycles (0 disables)
module s2p_deser
  import s2p_deser_pkg::*;
#(
  parameter int DWIDTH    = 4,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              din,
  input  logic              invalid,
  output logic [DWIDTH-1:0] outdata,
  output logic              outvalid,
  input  logic              outready,
  output logic              busy,
  output logic              overflow,
  output logic              abort
);

  localparam int BCNT_W = cnt_width(DWIDTH);
  localparam int ICNT_W = cnt_width(TIMEOUT + 1);

  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(DWIDTH - 1);
  localparam logic [BCNT_W-1:0] FIRST_CNT = BCNT_W'(1);
  localparam logic [ICNT_W-1:0] IDLE_LIM  = ICNT_W'(TIMEOUT);

  state_e            state_q;
  logic [BCNT_W-1:0] bitcnt_q;
  logic [ICNT_W-1:0] idlecnt_q;
  logic [ICNT_W-1:0] idlecnt_d;
  logic [DWIDTH-1:0] shreg_q;
  logic [DWIDTH-1:0] shreg_d;
  logic              busy_q;
  logic              abort_q;

  logic              word_vld;
  logic              timeout_hit;

  // MSB-first shifts left so the first bit ends at the top; LSB-first shifts
  // right so the first bit ends at bit 0.
  assign shreg_d = (MSB_FIRST != 0) ? {shreg_q[DWIDTH-2:0], din}
                                    : {din, shreg_q[DWIDTH-1:1]};

  assign idlecnt_d = idlecnt_q + ICNT_W'(1);

  // The shifted value is the completed word on the cycle the last bit lands,
  // so the output register captures it directly.
  assign word_vld = (state_q == ST_SHIFT) && invalid && (bitcnt_q == LAST_BIT);

  assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_SHIFT) && !invalid &&
                       (idlecnt_d == IDLE_LIM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      idlecnt_q <= '0;
      shreg_q   <= '0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (invalid) begin
            shreg_q   <= shreg_d;
            bitcnt_q  <= FIRST_CNT;
            idlecnt_q <= '0;
            state_q   <= ST_SHIFT;
            busy_q    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (invalid) begin
            idlecnt_q <= '0;
            if (bitcnt_q == LAST_BIT) begin
              // Word handed to the output register; start clean for the next.
              shreg_q  <= '0;
              bitcnt_q <= '0;
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
            end else begin
              shreg_q  <= shreg_d;
              bitcnt_q <= bitcnt_q + BCNT_W'(1);
            end
          end else if (timeout_hit) begin
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            idlecnt_q <= '0;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            abort_q   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            idlecnt_q <= idlecnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  s2p_outreg #(
    .DWIDTH(DWIDTH)
  ) u_outreg (
    .clk        (clk),
    .rstn       (rstn),
    .word_vld_i (word_vld),
    .word_dat_i (shreg_d),
    .outready_i (outready),
    .outdata_o  (outdata),
    .outvalid_o (outvalid),
    .overflow_o (overflow)
  );

  assign busy  = busy_q;
  assign abort = abort_q;

endmodule

// File: tb/tb_s2p_deser.sv
// Directed bench for s2p_deser: MSB-first and LSB-first instances share inputs.
module tb_s2p_deser;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       din = 1'b0;
  logic       invalid = 1'b0;
  logic       outready = 1'b0;
  logic [3:0] outdata, outdata_l;
  logic       outvalid, busy, overflow, abort;
  logic       outvalid_l, busy_l, overflow_l, abort_l;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  s2p_deser #(.DWIDTH(4), .MSB_FIRST(1), .TIMEOUT(8)) u_msb (
    .clk(clk), .rstn(rstn), .din(din), .invalid(invalid),
    .outdata(outdata), .outvalid(outvalid), .outready(outready),
    .busy(busy), .overflow(overflow), .abort(abort)
  );

  s2p_deser #(.DWIDTH(4), .MSB_FIRST(0), .TIMEOUT(8)) u_lsb (
    .clk(clk), .rstn(rstn), .din(din), .invalid(invalid),
    .outdata(outdata_l), .outvalid(outvalid_l), .outready(outready),
    .busy(busy_l), .overflow(overflow_l), .abort(abort_l)
  );

  // Drive one cycle of inputs at the falling edge; outputs seen at that
  // falling edge reflect all previous rising edges.
  task automatic step(input logic v, input logic b, input logic r);
    @(negedge clk);
    invalid  = v;
    din      = b;
    outready = r;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rstn = 1'b0; invalid = 1'b0; din = 1'b0; outready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (outdata !== 4'b0000 || outvalid !== 1'b0) begin errors++;
      $display("FAIL reset_out: outdata=%b outvalid=%b, expected 0000/0", outdata, outvalid); end
    checks++; if (busy !== 1'b0 || overflow !== 1'b0 || abort !== 1'b0) begin errors++;
      $display("FAIL reset_flags: busy=%b ovf=%b abort=%b, expected 0/0/0", busy, overflow, abort); end
    checks++; if (outdata_l !== 4'b0000 || outvalid_l !== 1'b0 || busy_l !== 1'b0 ||
                  overflow_l !== 1'b0 || abort_l !== 1'b0) begin errors++;
      $display("FAIL reset_lsb: outdata=%b vld=%b busy=%b ovf=%b abort=%b, expected all 0",
               outdata_l, outvalid_l, busy_l, overflow_l, abort_l); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    step(1, 1, 1); step(1, 0, 1);
    checks++; if (busy !== 1'b1 || outvalid !== 1'b0) begin errors++;
      $display("FAIL single_busy: busy=%b outvalid=%b, expected 1/0", busy, outvalid); end
    step(1, 1, 1); step(1, 0, 1); step(0, 0, 1);
    checks++; if (outvalid !== 1'b1 || outdata !== 4'b1010) begin errors++;
      $display("FAIL single_word: outvalid=%b outdata=%b, expected 1/1010", outvalid, outdata); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL single_idle: busy=%b, expected 0", busy); end
    step(0, 0, 1);
    checks++; if (outvalid !== 1'b0) begin errors++;
      $display("FAIL single_drop: outvalid=%b, expected 0", outvalid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bits;
    int ovf_seen;
    bits = 8'b1010_0101;
    ovf_seen = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, bits[7-i], 1);
      if (overflow) ovf_seen++;
      if (i == 4) begin
        checks++; if (outvalid !== 1'b1 || outdata !== 4'b1010) begin errors++;
          $display("FAIL b2b_word0: outvalid=%b outdata=%b, expected 1/1010", outvalid, outdata); end
      end
      if (i == 5) begin
        checks++; if (outvalid !== 1'b0) begin errors++;
          $display("FAIL b2b_gap: outvalid=%b, expected 0", outvalid); end
      end
    end
    step(0, 0, 1);
    if (overflow) ovf_seen++;
    checks++; if (outvalid !== 1'b1 || outdata !== 4'b0101) begin errors++;
      $display("FAIL b2b_word1: outvalid=%b outdata=%b, expected 1/0101", outvalid, outdata); end
    checks++; if (ovf_seen !== 0) begin errors++;
      $display("FAIL b2b_ovf: overflow pulses=%0d, expected 0", ovf_seen); end
  endtask

  task automatic test_overflow;
    logic [7:0] bits;
    int ovf_seen;
    bits = 8'b1010_0101;
    ovf_seen = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, bits[7-i], 0);
      if (overflow) ovf_seen++;
    end
    checks++; if (ovf_seen !== 0) begin errors++;
      $display("FAIL ovf_early: overflow pulses=%0d before 8th bit, expected 0", ovf_seen); end
    step(0, 0, 0);
    checks++; if (overflow !== 1'b1 || outvalid !== 1'b1 || outdata !== 4'b1010) begin errors++;
      $display("FAIL ovf_pulse: ovf=%b vld=%b outdata=%b, expected 1/1/1010", overflow, outvalid, outdata); end
    step(0, 0, 0);
    checks++; if (overflow !== 1'b0 || outdata !== 4'b1010) begin errors++;
      $display("FAIL ovf_hold: ovf=%b outdata=%b, expected 0/1010", overflow, outdata); end
    step(0, 0, 1);
    step(0, 0, 1);
    checks++; if (outvalid !== 1'b0) begin errors++;
      $display("FAIL ovf_xfer: outvalid=%b, expected 0", outvalid); end
  endtask

  task automatic test_simul;
    do_reset();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
    step(1, 0, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 1);
    step(0, 0, 1);
    checks++; if (outvalid !== 1'b1 || outdata !== 4'b0101 || overflow !== 1'b0) begin errors++;
      $display("FAIL simul_reload: vld=%b outdata=%b ovf=%b, expected 1/0101/0", outvalid, outdata, overflow); end
    step(0, 0, 1);
    checks++; if (outvalid !== 1'b0) begin errors++;
      $display("FAIL simul_drain: outvalid=%b, expected 0", outvalid); end
  endtask

  task automatic test_timeout;
    int abort_seen;
    abort_seen = 0;
    do_reset();
    step(1, 1, 1); step(1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1);
      if (abort) abort_seen++;
    end
    checks++; if (abort_seen !== 0 || busy !== 1'b1) begin errors++;
      $display("FAIL tmo_early: abort pulses=%0d busy=%b after 7 idle, expected 0/1", abort_seen, busy); end
    step(1, 1, 1);
    checks++; if (abort !== 1'b1 || busy !== 1'b0 || outvalid !== 1'b0) begin errors++;
      $display("FAIL tmo_abort: abort=%b busy=%b vld=%b, expected 1/0/0", abort, busy, outvalid); end
    step(1, 1, 1);
    checks++; if (abort !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL tmo_pulse: abort=%b busy=%b, expected 0/1", abort, busy); end
    step(1, 0, 1); step(1, 0, 1); step(0, 0, 1);
    checks++; if (outvalid !== 1'b1 || outdata !== 4'b1100) begin errors++;
      $display("FAIL tmo_next: vld=%b outdata=%b, expected 1/1100", outvalid, outdata); end
  endtask

  task automatic test_gap;
    int abort_seen;
    abort_seen = 0;
    do_reset();
    step(1, 1, 1); step(1, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1);
      if (abort) abort_seen++;
    end
    step(1, 1, 1);
    if (abort) abort_seen++;
    step(1, 1, 1);
    if (abort) abort_seen++;
    step(0, 0, 1);
    if (abort) abort_seen++;
    checks++; if (outvalid !== 1'b1 || outdata !== 4'b1011 || abort_seen !== 0) begin errors++;
      $display("FAIL gap_word: vld=%b outdata=%b aborts=%0d, expected 1/1011/0", outvalid, outdata, abort_seen); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(0, 0, 0);
    checks++; if (busy !== 1'b1 || outvalid !== 1'b1) begin errors++;
      $display("FAIL rmid_pre: busy=%b vld=%b, expected 1/1", busy, outvalid); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (outdata !== 4'b0000 || outvalid !== 1'b0 || busy !== 1'b0 ||
                  overflow !== 1'b0 || abort !== 1'b0) begin errors++;
      $display("FAIL rmid_async: outdata=%b vld=%b busy=%b ovf=%b abort=%b, expected all 0",
               outdata, outvalid, busy, overflow, abort); end
    @(negedge clk);
    rstn = 1'b1;
    step(1, 0, 1); step(1, 1, 1); step(1, 1, 1); step(1, 0, 1); step(0, 0, 1);
    checks++; if (outvalid !== 1'b1 || outdata !== 4'b0110) begin errors++;
      $display("FAIL rmid_fresh: vld=%b outdata=%b, expected 1/0110", outvalid, outdata); end
  endtask

  task automatic test_lsb;
    do_reset();
    step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1); step(0, 0, 1);
    checks++; if (outvalid_l !== 1'b1 || outdata_l !== 4'b0001) begin errors++;
      $display("FAIL lsb_word: vld=%b outdata=%b, expected 1/0001", outvalid_l, outdata_l); end
    checks++; if (outdata !== 4'b1000) begin errors++;
      $display("FAIL msb_word: outdata=%b, expected 1000", outdata); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simul();
    test_timeout();
    test_gap();
    test_reset_mid();
    test_lsb();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
